vmx_pe_simd: RTL
================

# vmx_pe_simd

Parametrised systolic vector-matrix processing element: one multiply-accumulate cell of the VMX array, generalised to configurable data width and SIMD lane count. It holds a double-buffered weight, a shadow register loaded by a countdown tag and an active register committed by a swap strobe, so the next weight tile streams in while the current one computes. Each cell forwards data, tag, mode and valid to its neighbour and emits a registered partial sum. Cells are chained along the array row and column.

## Interface
- DATA_W, 16, data/weight width; must be divisible by LANES
- LANES, 2, SIMD lane count in split mode; LW = DATA_W/LANES
- SUM_W, 2*DATA_W, partial-sum width; lane field AW = SUM_W/LANES
- TAG_W, 8, weight-tag width; MSB = load flag, low TAG_W-1 bits = countdown index
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- valid_in  in  1  beat qualifier for all inputs
- simd_mode  in  1  0 = full-width MAC, 1 = LANES independent lane MACs
- wtag_in  in  TAG_W  weight-load tag
- swap_in  in  1  commit shadow weight to active weight
- data_in  in  DATA_W  data or weight word
- sum_in  in  SUM_W  upstream partial sum
- valid_pass, simd_mode_pass, swap_pass  out  1  registered forwards
- wtag_pass  out  TAG_W  registered, decremented tag
- data_pass  out  DATA_W  registered data forward
- sum_out  out  SUM_W  registered partial sum
- ovf_out  out  LANES  per-field overflow of the current sum_out (full mode: bit 0 only)

## Operation
- All state updates only on beats with valid_in=1; with valid_in=0 every register holds except valid_pass, which becomes 0.
- Pass-through on a beat: valid_pass<=1, simd_mode_pass<=simd_mode, swap_pass<=swap_in, data_pass<=data_in, wtag_pass<={wtag_in[MSB], wtag_in[TAG_W-2:0]-1}. The index wraps modulo 2^(TAG_W-1) (0 -> all ones); the flag is never modified.
- Shadow load: on a beat with wtag_in[MSB]=1 and index==0, shadow_w<=data_in.
- Swap: on a beat with swap_in=1, active_w<=shadow_w. When load and swap fall on the same beat, active_w takes the OLD shadow and shadow_w takes data_in.
- MAC uses active_w as it stood before the beat, unsigned arithmetic:
  - simd_mode=0: sum_out <= (data_in*active_w + sum_in) mod 2^SUM_W; ovf_out[0] = carry out of SUM_W; other bits 0.
  - simd_mode=1: for lane i, field i of SUM_W (bits i*AW+:AW) <= (data lane i * weight lane i + sum_in field i) mod 2^AW; ovf_out[i] = carry out of that field. No carries cross fields.
- Mode is per beat; mixed-mode streams are legal.
- The weight-load beat also computes and forwards a sum; downstream ignores it by schedule.

## Timing
- Reset values: all outputs 0; shadow_w=0, active_w=0.
- Latency: exactly 1 clk from input beat to every output.
- Throughput: one beat per clk; no backpressure.
- Reset asserted mid-stream clears all state immediately, including both weights; the first beat after release sees active_w=0.

## Configuration
- VMX_PE_SAT_EN defined: any field (or the whole sum in full mode) whose carry is set is clamped to all ones; ovf_out is still reported.
- Undefined: results wrap modulo the field width; ovf_out is still reported.

## Test plan
- Reset: hold rst_n=0 and drive random inputs -> all outputs 0; release, send valid beat data 0x0005 with no prior load -> sum_out=sum_in.
- Load/swap, DATA_W=16, LANES=2: tag 0x80 with data 0x0302, then swap beat, then simd beat data 0x0405, sum_in 0 -> sum_out=0x000C000A, ovf_out=0; same in full mode -> 0x000C170A.
- Tag countdown: wtag_in=0x83 -> wtag_pass=0x82, no shadow load; wtag_in=0x00 -> wtag_pass=0x7F; wtag_in=0x80 -> wtag_pass=0xFF.
- Same-beat load+swap: shadow=0x0001, beat with tag 0x80, swap=1, data 0x0009 -> active=0x0001, shadow=0x0009; the following beat with swap=1 -> active=0x0009.
- Overflow: full mode, active=1, data 1, sum_in 0xFFFFFFFF -> ovf_out=1, sum_out 0x00000000 (wrap) or 0xFFFFFFFF (VMX_PE_SAT_EN); simd lane 1 overflow only -> ovf_out=2'b10, lane 0 field unaffected.
- Bubbles: valid_in=0 for 3 cycles between beats -> valid_pass=0, sum_out/data_pass/weights held, no tag decrement.

Source files
------------

// File: rtl/vmx_pe_simd.sv
`default_nettype none
// ============================================================================
//  Module   : vmx_pe_simd
//  Purpose  : Systolic vector-matrix processing element. It is one
//             multiply-accumulate cell of the VMX array, with configurable
//             data width and SIMD lane count. The weight is double-buffered:
//             a shadow register is loaded by a countdown tag, and an active
//             register is committed by a swap strobe. This lets the next
//             weight tile stream in while the current tile computes. Data,
//             tag, mode, swap and valid are forwarded one clock later to the
//             neighbouring cell, and a registered partial sum is emitted.
//  Options  : VMX_PE_SAT_EN - when defined, an overflowing field (or the
//             whole sum in full-width mode) is clamped to all ones instead
//             of wrapping. ovf_out is reported in both builds.
//  Ports    : clk, rst_n (async, active-low)
//             valid_in  - beat qualifier for all inputs
//             simd_mode - 0 full-width MAC, 1 LANES independent lane MACs
//             wtag_in   - {load flag, countdown index}
//             swap_in   - commit shadow weight to active weight
//             data_in   - data or weight word
//             sum_in    - upstream partial sum
//             valid_pass / simd_mode_pass / swap_pass / data_pass - forwards
//             wtag_pass - forwarded tag with the index decremented
//             sum_out   - registered partial sum
//             ovf_out   - per-field carry of sum_out (full mode: bit 0)
//  Revision : 1.0 - initial release
// ============================================================================
module vmx_pe_simd #(
   parameter int DATA_W = 16,
   parameter int LANES  = 2,
   parameter int SUM_W  = 2*DATA_W,
   parameter int TAG_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              valid_in,
   input  logic              simd_mode,
   input  logic [TAG_W-1:0]  wtag_in,
   input  logic              swap_in,
   input  logic [DATA_W-1:0] data_in,
   input  logic [SUM_W-1:0]  sum_in,
   output logic              valid_pass,
   output logic              simd_mode_pass,
   output logic              swap_pass,
   output logic [TAG_W-1:0]  wtag_pass,
   output logic [DATA_W-1:0] data_pass,
   output logic [SUM_W-1:0]  sum_out,
   output logic [LANES-1:0]  ovf_out
);

   localparam int LW  = DATA_W / LANES;   // lane data width
   localparam int AW  = SUM_W / LANES;    // lane accumulator field width
   localparam int FEW = SUM_W + 1;        // full sum plus carry
   localparam int LEW = AW + 1;           // lane field plus carry

   logic [DATA_W-1:0]   r_shadow_w;
   logic [DATA_W-1:0]   r_active_w;

   logic [2*DATA_W-1:0] w_full_prod;
   logic [SUM_W:0]      w_full_ext;
   logic [SUM_W-1:0]    w_full_res;
   logic [SUM_W-1:0]    w_simd_res;
   logic [LANES-1:0]    w_simd_ovf;
   logic [SUM_W-1:0]    w_sum_next;
   logic [LANES-1:0]    w_ovf_next;
   logic                w_load;
   logic [TAG_W-2:0]    w_idx_dec;

   // The shadow register captures data only when the countdown index has
   // reached this cell (index 0) and the load flag is set.
   assign w_load    = wtag_in[TAG_W-1] && (wtag_in[TAG_W-2:0] == '0);
   // The index wraps naturally: 0 - 1 gives all ones.
   assign w_idx_dec = wtag_in[TAG_W-2:0] - (TAG_W-1)'(1);

   // Full-width MAC. The operands are zero-extended so the product keeps
   // every bit before the carry out of SUM_W is extracted.
   assign w_full_prod = {{DATA_W{1'b0}}, data_in} * {{DATA_W{1'b0}}, r_active_w};
   assign w_full_ext  = {1'b0, sum_in} + FEW'(w_full_prod);

`ifdef VMX_PE_SAT_EN
   assign w_full_res = w_full_ext[SUM_W] ? {SUM_W{1'b1}} : w_full_ext[SUM_W-1:0];
`else
   assign w_full_res = w_full_ext[SUM_W-1:0];
`endif

   // Lane MACs. Each field has its own adder, so no carry crosses a field.
   generate
      for (genvar i = 0; i < LANES; i++) begin : g_lane
         logic [2*LW-1:0] w_prod;
         logic [AW:0]     w_ext;

         assign w_prod = {{LW{1'b0}}, data_in[i*LW +: LW]}
                       * {{LW{1'b0}}, r_active_w[i*LW +: LW]};
         assign w_ext  = {1'b0, sum_in[i*AW +: AW]} + LEW'(w_prod);
         assign w_simd_ovf[i] = w_ext[AW];
`ifdef VMX_PE_SAT_EN
         assign w_simd_res[i*AW +: AW] = w_ext[AW] ? {AW{1'b1}} : w_ext[AW-1:0];
`else
         assign w_simd_res[i*AW +: AW] = w_ext[AW-1:0];
`endif
      end
   endgenerate

   assign w_sum_next = simd_mode ? w_simd_res : w_full_res;
   assign w_ovf_next = simd_mode ? w_simd_ovf : LANES'(w_full_ext[SUM_W]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shadow_w     <= '0;
         r_active_w     <= '0;
         valid_pass     <= 1'b0;
         simd_mode_pass <= 1'b0;
         swap_pass      <= 1'b0;
         wtag_pass      <= '0;
         data_pass      <= '0;
         sum_out        <= '0;
         ovf_out        <= '0;
      end else begin
         valid_pass <= valid_in;
         if (valid_in) begin
            simd_mode_pass <= simd_mode;
            swap_pass      <= swap_in;
            data_pass      <= data_in;
            wtag_pass      <= {wtag_in[TAG_W-1], w_idx_dec};
            sum_out        <= w_sum_next;
            ovf_out        <= w_ovf_next;
            // On a beat that both loads and swaps, active takes the old
            // shadow value, because both assignments sample pre-edge values.
            if (w_load) begin
               r_shadow_w <= data_in;
            end
            if (swap_in) begin
               r_active_w <= r_shadow_w;
            end
         end
      end
   end

endmodule
`default_nettype wire
